// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the AHB-to-APB bridge: the bridge FSM state
// encoding, the slave index constants and the default address-decode bases.
// No ports; imported by apb_addr_decode and apb_ctrl.
// ----------------------------------------------------------------------------
package apb_pkg;

    // Bridge sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        ERR1   = 3'd3,
        ERR2   = 3'd4
    } apbState_t;

    // Bit positions of each slave inside the one-hot PSEL / PREADY / PSLVERR.
    localparam int SLV_UART  = 0;
    localparam int SLV_TIMER = 1;
    localparam int NUM_SLV   = 2;

    // Default 4 KB page bases, compared against HADDR[31:12].
    localparam logic [19:0] DEF_UART_BASE  = 20'h4000D;
    localparam logic [19:0] DEF_TIMER_BASE = 20'h4000E;

    // Default abort threshold in ACCESS cycles.
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// ----------------------------------------------------------------------------
// apb_addr_decode
// Purely combinational page decoder. The upper 20 address bits are compared
// for equality against each slave base; a miss on every slave raises the
// unmapped flag so the bridge can answer with an AHB error instead of
// issuing an APB cycle.
//
// Ports
//   i_addrHi   in  20  HADDR[31:12]
//   o_sel      out  2  one-hot slave select (bit SLV_UART / SLV_TIMER)
//   o_unmapped out  1  no slave matched
// ----------------------------------------------------------------------------
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter logic [19:0] UART_BASE  = DEF_UART_BASE,
    parameter logic [19:0] TIMER_BASE = DEF_TIMER_BASE
) (
    input  logic [19:0]        i_addrHi,
    output logic [NUM_SLV-1:0] o_sel,
    output logic               o_unmapped
);

    logic [NUM_SLV-1:0] w_hit;

    // Equality match per slave page. Bases are required to differ, so at
    // most one bit can be set and the result is one-hot or zero.
    always_comb begin
        w_hit            = '0;
        w_hit[SLV_UART]  = (i_addrHi == UART_BASE);
        w_hit[SLV_TIMER] = (i_addrHi == TIMER_BASE);
    end

    assign o_sel      = w_hit;
    assign o_unmapped = ~|w_hit;

endmodule

// File: rtl/apb_ctrl.sv
// ----------------------------------------------------------------------------
// apb_ctrl
// AHB-Lite slave to APB master bridge serving two APB slaves (UART, timer).
// An accepted AHB address phase is registered, decoded and turned into an
// APB SETUP + ACCESS sequence. Unmapped addresses, slave errors and slaves
// that never assert PREADY produce the two-cycle AHB error response.
//
// Ports
//   PCLK       in   1  clock, rising edge
//   PRESET     in   1  synchronous active-high reset
//   HSEL       in   1  AHB select for the APB region
//   HTRANS     in   2  AHB transfer type (bit1 = NONSEQ/SEQ)
//   HREADY     in   1  AHB bus ready
//   HADDR      in  32  AHB address
//   HWRITE     in   1  AHB direction
//   HWDATA     in  32  AHB write data (data phase)
//   HRDATA     out 32  read data, zero outside completing ACCESS cycles
//   HREADYOUT  out  1  transfer complete
//   HRESP      out  1  error response
//   PSEL       out  2  one-hot APB slave select
//   PENABLE    out  1  APB access phase
//   PWRITE     out  1  APB direction
//   PADDR      out 32  APB address
//   PWDATA     out 32  APB write data
//   PRDATA0/1  in  32  slave read data
//   PREADY     in   2  per-slave ready
//   PSLVERR    in   2  per-slave error
// ----------------------------------------------------------------------------
module apb_ctrl
    import apb_pkg::*;
#(
    parameter logic [19:0] UART_BASE  = DEF_UART_BASE,
    parameter logic [19:0] TIMER_BASE = DEF_TIMER_BASE,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               HSEL,
    input  logic [1:0]         HTRANS,
    input  logic               HREADY,
    input  logic [31:0]        HADDR,
    input  logic               HWRITE,
    input  logic [31:0]        HWDATA,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [NUM_SLV-1:0] PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PADDR,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA0,
    input  logic [31:0]        PRDATA1,
    input  logic [NUM_SLV-1:0] PREADY,
    input  logic [NUM_SLV-1:0] PSLVERR
);

    // Wait count value on which a still-stalled ACCESS is abandoned.
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT - 1);

    apbState_t          r_state;
    apbState_t          w_nextState;
    logic [31:0]        r_paddr;
    logic [31:0]        r_pwdata;
    logic               r_pwrite;
    logic [NUM_SLV-1:0] r_sel;
    logic [7:0]         r_waitCnt;

    logic [NUM_SLV-1:0] w_decSel;
    logic               w_decUnmapped;
    logic               w_pready;
    logic               w_pslverr;
    logic [31:0]        w_prdata;
    logic               w_complete;
    logic               w_timeout;
    logic               w_accept;
    logic               w_unused;

    // HTRANS[0] only separates SEQ from NONSEQ, which the bridge treats alike.
    assign w_unused = HTRANS[0];

    apb_addr_decode #(
        .UART_BASE  (UART_BASE),
        .TIMER_BASE (TIMER_BASE)
    ) u_addrDecode (
        .i_addrHi   (HADDR[31:12]),
        .o_sel      (w_decSel),
        .o_unmapped (w_decUnmapped)
    );

    // Only the addressed slave's handshake and data are looked at; the
    // other slave's PREADY/PSLVERR/PRDATA are don't-care for this transfer.
    assign w_pready  = |(PREADY & r_sel);
    assign w_pslverr = |(PSLVERR & r_sel);
    assign w_prdata  = r_sel[SLV_TIMER] ? PRDATA1 : PRDATA0;

    // A completing ACCESS is the only ACCESS cycle with HREADYOUT high, and
    // is therefore the only ACCESS cycle where a pipelined address phase
    // can be taken. PREADY is tested first so it beats the terminal count.
    assign w_complete = (r_state == ACCESS) && w_pready && !w_pslverr;
    assign w_timeout  = (r_state == ACCESS) && !w_pready && (r_waitCnt == TIMEOUT_TC);

    // New transfers are taken only while the bridge is signalling ready and
    // is free to start one: in IDLE or in the last cycle of a good ACCESS.
    // The second error cycle is deliberately excluded because the master is
    // expected to cancel its next transfer after an error.
    assign w_accept = HSEL && HTRANS[1] && HREADY && ((r_state == IDLE) || w_complete);

    // State register; reset drops back to IDLE, which also abandons any
    // transfer in flight without giving the master a response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Address-phase capture, data-phase write data capture and the ACCESS
    // wait counter. PADDR/PWRITE/PWDATA only change when a new transfer
    // loads them, so they hold their last value between transfers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_sel     <= '0;
            r_waitCnt <= '0;
        end else begin
            if (w_accept) begin
                r_paddr  <= HADDR;
                r_pwrite <= HWRITE;
                r_sel    <= w_decSel;
            end
            if (r_state == SETUP) begin
                r_pwdata  <= HWDATA;
                r_waitCnt <= '0;
            end else if ((r_state == ACCESS) && !w_pready) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
        end
    end

    // Next-state and bus outputs. Defaults describe IDLE; each state only
    // overrides what differs from it.
    always_comb begin
        w_nextState = r_state;
        PSEL        = '0;
        PENABLE     = 1'b0;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_decUnmapped ? ERR1 : SETUP;
                end
            end
            SETUP: begin
                PSEL        = r_sel;
                HREADYOUT   = 1'b0;
                w_nextState = ACCESS;
            end
            ACCESS: begin
                PSEL      = r_sel;
                PENABLE   = 1'b1;
                HREADYOUT = 1'b0;
                if (w_pready) begin
                    if (w_pslverr) begin
                        HRESP       = 1'b1;
                        w_nextState = ERR2;
                    end else begin
                        HREADYOUT = 1'b1;
                        HRDATA    = w_prdata;
                        if (w_accept) begin
                            w_nextState = w_decUnmapped ? ERR1 : SETUP;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end
                end else if (w_timeout) begin
                    HRESP       = 1'b1;
                    w_nextState = ERR2;
                end
            end
            ERR1: begin
                HRESP       = 1'b1;
                HREADYOUT   = 1'b0;
                w_nextState = ERR2;
            end
            ERR2: begin
                HRESP       = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign PADDR  = r_paddr;
    assign PWRITE = r_pwrite;
    assign PWDATA = r_pwdata;

endmodule
